// File: rtl/pulse_rate_sequencer.sv
// pulse_rate_sequencer: divides clk into a blink/square wave at a slow or fast rate,
//   either fixed by sw or alternating in auto bursts separated by a pause.
// Latency: all outputs registered; the first toggle lands DIV cycles after run entry.
// Backpressure: none; start/stop are level inputs sampled every cycle, and stop wins.
// Optional feature macro: PRS_TICK_COUNT_EN adds the tick_count[15:0] output.
// Ports:
//   clk, reset (async, active-low)           - clock and reset
//   start, stop, auto_mode, sw               - board controls
//   clk_out, tick, burst_done                - divided wave, toggle strobe, burst strobe
//   busy, phase[1:0]                         - status: 0 IDLE, 1 SLOW, 2 FAST, 3 PAUSE
//   tick_count[15:0] (PRS_TICK_COUNT_EN only) - ticks since the last start from IDLE
module pulse_rate_sequencer #(
  parameter int CNT_W     = 28,
  parameter int SLOW_DIV  = 12_500_000,
  parameter int FAST_DIV  = 6_250_000,
  parameter int BURST_LEN = 8,
  parameter int PAUSE_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_mode,
  input  logic       sw,
  output logic       clk_out,
  output logic       tick,
  output logic       busy,
  output logic [1:0] phase,
  output logic       burst_done
`ifdef PRS_TICK_COUNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  // Elaboration-time parameter checks
  if (SLOW_DIV < 2) begin : g_err_slow_min
    $error("SLOW_DIV must be at least 2");
  end
  if (FAST_DIV < 2) begin : g_err_fast_min
    $error("FAST_DIV must be at least 2");
  end
  if (PAUSE_CYC < 1) begin : g_err_pause_min
    $error("PAUSE_CYC must be at least 1");
  end
  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_err_burst
    $error("BURST_LEN must be in 1..255");
  end
  if ((longint'(SLOW_DIV) - 1) >= (longint'(1) << CNT_W)) begin : g_err_slow_fit
    $error("SLOW_DIV-1 does not fit in CNT_W");
  end
  if ((longint'(FAST_DIV) - 1) >= (longint'(1) << CNT_W)) begin : g_err_fast_fit
    $error("FAST_DIV-1 does not fit in CNT_W");
  end
  if ((longint'(PAUSE_CYC) - 1) >= (longint'(1) << CNT_W)) begin : g_err_pause_fit
    $error("PAUSE_CYC-1 does not fit in CNT_W");
  end

  localparam int TOG_W = $clog2(2 * BURST_LEN + 1);

  localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic [TOG_W-1:0] TOG_END    = TOG_W'(2 * BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOW  = 2'd1,
    ST_FAST  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  state_e             next_rate_q, next_rate_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               burst_done_q, burst_done_d;

  // Shared event decode used by both the next-state and output processes
  logic               running;
  logic [CNT_W-1:0]   cur_last;
  logic               hit;
  logic [TOG_W-1:0]   tog_inc;
  logic               burst_end;
  logic               pause_end;
  logic               launch;
  state_e             fixed_rate;

  always_comb begin
    running    = (state_q == ST_SLOW) || (state_q == ST_FAST);
    cur_last   = (state_q == ST_SLOW) ? SLOW_LAST : FAST_LAST;
    hit        = running && !stop && (cnt_q == cur_last);
    // Saturate so a long fixed-mode run cannot wrap past the burst threshold;
    // switching to auto then closes the burst at the next toggle.
    tog_inc    = (tog_q >= TOG_END) ? TOG_END : tog_q + 1'b1;
    burst_end  = hit && auto_mode && (tog_inc >= TOG_END);
    pause_end  = (state_q == ST_PAUSE) && !stop && (cnt_q == PAUSE_LAST);
    launch     = (state_q == ST_IDLE) && start && !stop;
    fixed_rate = sw ? ST_SLOW : ST_FAST;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      next_rate_q  <= ST_SLOW;
      cnt_q        <= '0;
      tog_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_rate_q  <= next_rate_d;
      cnt_q        <= cnt_d;
      tog_q        <= tog_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    next_rate_d = next_rate_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) state_d = auto_mode ? ST_SLOW : fixed_rate;
      end
      ST_SLOW, ST_FAST: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (burst_end) begin
          state_d     = ST_PAUSE;
          next_rate_d = (state_q == ST_SLOW) ? ST_FAST : ST_SLOW;
        end else if (hit && !auto_mode) begin
          // Fixed mode: sw only takes effect on a toggle edge
          state_d = fixed_rate;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause_end) begin
          state_d = auto_mode ? next_rate_q : fixed_rate;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d        = cnt_q;
    tog_d        = tog_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    burst_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        tog_d     = '0;
        clk_out_d = 1'b0;
      end
      ST_SLOW, ST_FAST: begin
        if (stop) begin
          cnt_d     = '0;
          tog_d     = '0;
          clk_out_d = 1'b0;
        end else if (hit) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = 1'b1;
          tog_d     = tog_inc;
          if (burst_end) begin
            burst_done_d = 1'b1;
            tog_d        = '0;
            clk_out_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        clk_out_d = 1'b0;
        if (stop) begin
          cnt_d = '0;
          tog_d = '0;
        end else if (pause_end) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d     = '0;
        tog_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

`ifdef PRS_TICK_COUNT_EN
  logic [15:0] tick_count_q, tick_count_d;

  // Cleared on each start from IDLE; holds through PAUSE and after stop
  always_comb begin
    tick_count_d = tick_count_q;
    if (launch) begin
      tick_count_d = '0;
    end else if (hit) begin
      tick_count_d = tick_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_count_q <= '0;
    else        tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`endif

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign burst_done = burst_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign phase      = state_q;

endmodule

// File: tb/tb_pulse_rate_sequencer.sv
// Directed bench for pulse_rate_sequencer with SLOW_DIV=4, FAST_DIV=2,
// BURST_LEN=2, PAUSE_CYC=3. Inputs driven and outputs sampled on negedge.
module tb_pulse_rate_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_mode = 1'b0;
  logic       sw = 1'b0;
  logic       clk_out, tick, busy, burst_done;
  logic [1:0] phase;
`ifdef PRS_TICK_COUNT_EN
  logic [15:0] tick_count;
`endif

  int errors = 0;
  int checks = 0;

  pulse_rate_sequencer #(
    .CNT_W(8), .SLOW_DIV(4), .FAST_DIV(2), .BURST_LEN(2), .PAUSE_CYC(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .auto_mode(auto_mode), .sw(sw), .clk_out(clk_out), .tick(tick),
    .busy(busy), .phase(phase), .burst_done(burst_done)
`ifdef PRS_TICK_COUNT_EN
    , .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance negedge by negedge until tick is seen or the limit expires; n is
  // the number of cycles waited (equals limit on timeout, which callers flag).
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < limit);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_out, tick, busy, phase, burst_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {clk_out, tick, busy, phase, burst_done});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_idle: phase got %0d want 0", phase);
    end
  endtask

  task automatic test_fixed_slow;
    int n;
    auto_mode = 1'b0; sw = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (phase !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL slow_entry: phase=%0d busy=%b want phase=1 busy=1", phase, busy);
    end
    wait_tick(20, n);
    checks++;
    if (n != 4 || clk_out !== 1'b1) begin
      errors++;
      $display("FAIL slow_first_tick: cycles=%0d clk_out=%b want 4 and 1", n, clk_out);
    end
    // start while busy must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL start_while_busy: phase got %0d want 1", phase);
    end
    wait_tick(20, n);
    checks++;
    if (n != 3 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL slow_second_tick: cycles=%0d clk_out=%b want 3 and 0", n, clk_out);
    end
    wait_tick(20, n);
    checks++;
    if (n != 4 || clk_out !== 1'b1) begin
      errors++;
      $display("FAIL slow_period: cycles=%0d clk_out=%b want 4 and 1", n, clk_out);
    end
  endtask

  task automatic test_rate_switch;
    int n;
    @(negedge clk);
    sw = 1'b0;
    @(negedge clk);
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL switch_mid_half: phase got %0d want 1", phase);
    end
    wait_tick(20, n);
    checks++;
    if (n != 2 || phase !== 2'd2 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL switch_edge: cycles=%0d phase=%0d clk_out=%b want 2,2,0", n, phase, clk_out);
    end
    wait_tick(20, n);
    checks++;
    if (n != 2 || clk_out !== 1'b1) begin
      errors++;
      $display("FAIL fast_tick1: cycles=%0d clk_out=%b want 2 and 1", n, clk_out);
    end
    wait_tick(20, n);
    checks++;
    if (n != 2 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL fast_tick2: cycles=%0d clk_out=%b want 2 and 0", n, clk_out);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({clk_out, tick, busy, phase} !== 5'b0) begin
      errors++;
      $display("FAIL stop_idle: got %b want 00000", {clk_out, tick, busy, phase});
    end
  endtask

  task automatic test_auto_burst;
    int n;
    auto_mode = 1'b1; sw = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL auto_entry: phase got %0d want 1", phase);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        wait_tick(20, n);
        checks++;
        if (n != (r == 0 ? 4 : 2)) begin
          errors++;
          $display("FAIL auto_spacing r%0d t%0d: cycles=%0d want %0d", r, i, n, (r == 0 ? 4 : 2));
        end
        checks++;
        if (i < 3) begin
          if (burst_done !== 1'b0 || clk_out !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL auto_mid r%0d t%0d: burst_done=%b clk_out=%b", r, i, burst_done, clk_out);
          end
        end else begin
          if (burst_done !== 1'b1 || clk_out !== 1'b0 || phase !== 2'd3) begin
            errors++;
            $display("FAIL auto_burst_end r%0d: burst_done=%b clk_out=%b phase=%0d want 1,0,3",
                     r, burst_done, clk_out, phase);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (burst_done !== 1'b0 || tick !== 1'b0 || phase !== 2'd3) begin
        errors++;
        $display("FAIL pause1 r%0d: burst_done=%b tick=%b phase=%0d want 0,0,3", r, burst_done, tick, phase);
      end
      @(negedge clk);
      checks++;
      if (tick !== 1'b0 || phase !== 2'd3 || clk_out !== 1'b0) begin
        errors++;
        $display("FAIL pause2 r%0d: tick=%b phase=%0d clk_out=%b want 0,3,0", r, tick, phase, clk_out);
      end
      @(negedge clk);
      checks++;
      if (phase !== (r == 0 ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL pause_exit r%0d: phase got %0d want %0d", r, phase, (r == 0 ? 2 : 1));
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    auto_mode = 1'b0;
  endtask

  task automatic test_collision;
    sw = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("FAIL coll_entry_fast: phase got %0d want 2", phase);
    end
    // Next edge would be a toggle edge; stop must suppress the tick
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    checks++;
    if ({clk_out, tick, busy, phase} !== 5'b0) begin
      errors++;
      $display("FAIL coll_running: got %b want 00000", {clk_out, tick, busy, phase});
    end
    @(negedge clk);
    checks++;
    if (phase !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_idle: phase=%0d busy=%b want 0,0", phase, busy);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_async_reset;
    int n;
    sw = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick(20, n);
    checks++;
    if (n != 2 || clk_out !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: cycles=%0d clk_out=%b want 2 and 1", n, clk_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, busy, phase, burst_done} !== 6'b0) begin
      errors++;
      $display("FAIL areset_immediate: got %b want 000000", {clk_out, tick, busy, phase, burst_done});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 2'd0 || busy !== 1'b0 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_stays_idle: phase=%0d busy=%b clk_out=%b", phase, busy, clk_out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("FAIL areset_restart: phase got %0d want 2", phase);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

`ifdef PRS_TICK_COUNT_EN
  task automatic test_tick_count;
    int n;
    int bad;
    bad = 0;
    sw = 1'b0; auto_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      wait_tick(4, n);
      if (n != 2) bad++;
    end
    checks++;
    if (bad != 0 || tick_count !== 16'd4464) begin
      errors++;
      $display("FAIL tick_count_wrap: count=%0d bad_spacing=%0d want 4464 and 0", tick_count, bad);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (tick_count !== 16'd4464) begin
      errors++;
      $display("FAIL tick_count_hold: got %0d want 4464", tick_count);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tick_count !== 16'd0) begin
      errors++;
      $display("FAIL tick_count_clear: got %0d want 0", tick_count);
    end
    wait_tick(4, n);
    checks++;
    if (tick_count !== 16'd1) begin
      errors++;
      $display("FAIL tick_count_first: got %0d want 1", tick_count);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_slow();
    test_rate_switch();
    test_auto_burst();
    test_collision();
    test_async_reset();
`ifdef PRS_TICK_COUNT_EN
    test_tick_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_rate_sequencer.md
Name: pulse_rate_sequencer

Overview:
- Controller that drives the board's square-wave/blink clock path.
- Owns the divide counter and sequences between a slow rate and a fast rate, either fixed by switch or auto-alternating in bursts with a pause between bursts.
- Sits between board switches/buttons and the LED/pulse output.
- Provides start/stop control, a per-toggle tick strobe and status for downstream logic.

Parameters:
- CNT_W, 28, width of divide counter.
- SLOW_DIV, 12_500_000, clk cycles per half-period in slow rate.
- FAST_DIV, 6_250_000, clk cycles per half-period in fast rate.
- BURST_LEN, 8, full output periods per burst in auto mode (valid range 1..255).
- PAUSE_CYC, 25_000_000, clk cycles of pause between bursts in auto mode (must be at least 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  level, sampled each cycle; starts sequencing from IDLE.
- stop  in  1  level, sampled each cycle; returns to IDLE.
- auto_mode  in  1  1 = alternate slow/fast bursts; 0 = fixed rate from sw.
- sw  in  1  rate select when auto_mode=0: 1 = slow, 0 = fast.
- clk_out  out  1  divided square wave.
- tick  out  1  one-cycle strobe coincident with each clk_out toggle.
- busy  out  1  high in any state other than IDLE.
- phase  out  2  state code: 0 IDLE, 1 SLOW, 2 FAST, 3 PAUSE.
- burst_done  out  1  one-cycle strobe when an auto-mode burst completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; cnt=0, toggle count=0.
  - clk_out=0, tick=0, burst_done=0, busy=0, phase=0.
- All outputs are registered.
- IDLE:
  - cnt and clk_out are held at 0.
  - When start=1 and stop=0:
    - With auto_mode=1, go to SLOW.
    - With auto_mode=0, go to SLOW if sw=1, else FAST.
  - cnt=0 on entry.
- SLOW/FAST:
  - cnt increments each cycle.
  - When cnt==DIV-1 (DIV is per state), in the same edge:
    - cnt goes to 0 and clk_out toggles.
    - tick=1 for one cycle.
    - toggle count increments.
  - First toggle occurs DIV cycles after entry, so the output period is 2*DIV.
- Fixed mode (auto_mode=0):
  - sw is sampled only at toggle edges.
  - If sw selects the other rate, the state switches at that edge; cnt restarts at 0 and clk_out still toggles.
- Auto mode:
  - When the toggle count reaches 2*BURST_LEN (on that toggle edge, clk_out returns to 0), burst_done=1 for one cycle.
  - The toggle count clears and the state goes to PAUSE, remembering the next rate (the opposite of the current one).
- PAUSE:
  - clk_out=0, no ticks.
  - cnt counts to PAUSE_CYC-1, then cnt=0 and the state goes to the remembered rate.
- Mode changes:
  - auto_mode changes are sampled only at toggle edges or at PAUSE exit.
  - Clearing auto_mode during PAUSE ends the pause at its expiry in the sw-selected rate.
- stop=1 in any non-IDLE state: next edge goes to IDLE, clk_out=0, cnt=0, toggle count=0. No tick or burst_done is issued on that edge.
- start and stop asserted together: stop wins.
- start while busy is ignored.
- Reset mid-operation: immediate return to reset values; no partial strobes.
- busy and phase reflect the registered state.
- Counter width: DIV-1 and PAUSE_CYC-1 must fit in CNT_W.
- Elaboration checks: SLOW_DIV ≥ 2, FAST_DIV ≥ 2, and DIV/PAUSE values that do not fit CNT_W are an elaboration error.

Optional Feature:
- Macro PRS_TICK_COUNT_EN.
- When defined:
  - Adds output tick_count[15:0].
  - Counts ticks since the last IDLE→run transition.
  - Cleared on reset and on entry from IDLE; wraps 0xFFFF→0; holds its value in PAUSE and after stop.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan (parameters SLOW_DIV=4, FAST_DIV=2, BURST_LEN=2, PAUSE_CYC=3):
- Fixed slow: reset released, auto_mode=0, sw=1, 1-cycle start pulse.
  - Expect phase=1, busy=1, first tick 4 cycles after entry.
  - Expect clk_out period 8 cycles and ticks every 4 cycles.
- Rate switch: fixed slow running, set sw=0 mid half-period.
  - Switch to FAST (phase=2) occurs only at the next toggle edge.
  - Ticks then every 2 cycles.
- Auto burst: auto_mode=1, start.
  - 4 ticks at 4-cycle spacing; burst_done pulse coincident with the 4th tick, clk_out=0.
  - PAUSE for 3 cycles with no ticks.
  - Then FAST: 4 ticks at 2-cycle spacing, then PAUSE, then back to SLOW.
- Stop/start collision: in FAST, assert start=1 and stop=1 together.
  - Next cycle: IDLE, clk_out=0, busy=0, no tick.
  - Repeat the collision in IDLE: remains IDLE.
- Async reset mid-run: drop reset between clock edges during FAST.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, stays IDLE until start.
- PRS_TICK_COUNT_EN defined: run 70000 ticks in fast mode.
  - tick_count wraps to 4464.
  - Stop, then start: count returns to 0 then increments from 1 on the first tick.
